// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words and writes them to instruction memory,
// holding the core in reset until the image is complete. Optional macro: IMEM_LOADER_CHECKSUM_EN (trailing XOR byte).
module imem_loader #(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_byte,
   input  logic        in_last,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        core_reset,
   output logic        done,
   output logic        error,
   output logic [15:0] words_loaded
);

   // state    | meaning
   // ST_LOAD  | accepting image bytes, core held in reset
   // ST_DONE  | image complete, core released
   // ST_ERROR | overflow or checksum mismatch, core held in reset
   typedef enum logic [1:0] {ST_LOAD, ST_DONE, ST_ERROR} state_t;

   localparam logic [15:0] DEPTH_W = 16'(DEPTH_WORDS);

   state_t      state_q, state_d;
   logic [1:0]  lane_q, lane_d;
   logic [31:0] word_q, word_d, word_cur;
   logic [7:0]  xor_q, xor_d;
   logic        is_data, overflow, complete;
   logic        in_ready_d, imem_we_d, core_reset_d, done_d, error_d;
   logic [31:0] imem_addr_d, imem_wdata_d;
   logic [15:0] words_loaded_d;

   always_comb begin
      state_d        = state_q;
      lane_d         = lane_q;
      word_d         = word_q;
      xor_d          = xor_q;
      word_cur       = word_q;
      imem_we_d      = 1'b0;
      imem_addr_d    = imem_addr;
      imem_wdata_d   = imem_wdata;
      words_loaded_d = words_loaded;
`ifdef IMEM_LOADER_CHECKSUM_EN
      is_data        = !in_last;
`else
      is_data        = 1'b1;
`endif
      overflow       = is_data && (lane_q == 2'd0) && (words_loaded == DEPTH_W);
      complete       = 1'b0;

      if (state_q == ST_LOAD && in_valid && in_ready) begin
         if (overflow) begin
            state_d = ST_ERROR;
         end else begin
            if (is_data) begin
               word_cur[{lane_q, 3'b000} +: 8] = in_byte;
               xor_d    = xor_q ^ in_byte;
               lane_d   = lane_q + 2'd1;
               complete = (lane_q == 2'd3) || in_last;
            end else begin
               // trailing checksum byte only flushes a partially filled word
               complete = (lane_q != 2'd0);
            end
            word_d = word_cur;
            if (complete) begin
               imem_we_d      = 1'b1;
               imem_addr_d    = BASE_ADDR + {14'd0, words_loaded, 2'b00};
               imem_wdata_d   = word_cur;
               words_loaded_d = words_loaded + 16'd1;
               word_d         = 32'd0;
               lane_d         = 2'd0;
            end
            if (in_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = (in_byte == xor_q) ? ST_DONE : ST_ERROR;
`else
               state_d = ST_DONE;
`endif
            end
         end
      end

      in_ready_d   = (state_d == ST_LOAD);
      core_reset_d = (state_d != ST_DONE);
      done_d       = (state_d == ST_DONE);
      error_d      = (state_d == ST_ERROR);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_LOAD;
         lane_q       <= 2'd0;
         word_q       <= 32'd0;
         xor_q        <= 8'd0;
         in_ready     <= 1'b0;
         imem_we      <= 1'b0;
         imem_addr    <= 32'd0;
         imem_wdata   <= 32'd0;
         core_reset   <= 1'b1;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= 16'd0;
      end else begin
         state_q      <= state_d;
         lane_q       <= lane_d;
         word_q       <= word_d;
         xor_q        <= xor_d;
         in_ready     <= in_ready_d;
         imem_we      <= imem_we_d;
         imem_addr    <= imem_addr_d;
         imem_wdata   <= imem_wdata_d;
         core_reset   <= core_reset_d;
         done         <= done_d;
         error        <= error_d;
         words_loaded <= words_loaded_d;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: instance a (256 words @0x0) and instance b (3 words @0x100).
// Inputs are shared; the instance not under test is held in reset.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        ra = 1'b1, rb = 1'b1;
   logic        in_valid = 1'b0, in_last = 1'b0;
   logic [7:0]  in_byte = 8'd0;
   logic        sel = 1'b0;

   logic        a_ready, a_we, a_core_reset, a_done, a_error;
   logic [31:0] a_addr, a_wdata;
   logic [15:0] a_wl;
   logic        b_ready, b_we, b_core_reset, b_done, b_error;
   logic [31:0] b_addr, b_wdata;
   logic [15:0] b_wl;
   logic        rdy;

   int errors = 0;
   int checks = 0;
   logic [31:0] qa_addr[$], qa_data[$], qb_addr[$], qb_data[$];

   always #5 clk = ~clk;
   assign rdy = sel ? b_ready : a_ready;

   imem_loader u_a (
      .clk(clk), .reset(ra), .in_valid(in_valid), .in_ready(a_ready), .in_byte(in_byte),
      .in_last(in_last), .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
      .core_reset(a_core_reset), .done(a_done), .error(a_error), .words_loaded(a_wl));

   imem_loader #(.DEPTH_WORDS(3), .BASE_ADDR(32'h100)) u_b (
      .clk(clk), .reset(rb), .in_valid(in_valid), .in_ready(b_ready), .in_byte(in_byte),
      .in_last(in_last), .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
      .core_reset(b_core_reset), .done(b_done), .error(b_error), .words_loaded(b_wl));

   always @(negedge clk) begin
      if (a_we) begin qa_addr.push_back(a_addr); qa_data.push_back(a_wdata); end
      if (b_we) begin qb_addr.push_back(b_addr); qb_data.push_back(b_wdata); end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b, input logic l);
      int n = 0;
      in_valid = 1'b1; in_byte = b; in_last = l;
      while (!rdy && n < 20) begin @(negedge clk); n++; end
      if (!rdy) chk("send_ready_timeout", 32'(rdy), 32'd1);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic reset_a();
      ra = 1'b1; @(negedge clk); ra = 1'b0;
      qa_addr.delete(); qa_data.delete();
   endtask

   task automatic reset_b();
      rb = 1'b1; @(negedge clk); rb = 1'b0;
      qb_addr.delete(); qb_data.delete();
   endtask

   initial begin
      idle(2);
      sel = 1'b0;
      reset_a();
      chk("rst_ready", 32'(a_ready), 32'd0);
      chk("rst_we", 32'(a_we), 32'd0);
      chk("rst_addr", a_addr, 32'd0);
      chk("rst_wdata", a_wdata, 32'd0);
      chk("rst_core_reset", 32'(a_core_reset), 32'd1);
      chk("rst_done", 32'(a_done), 32'd0);
      chk("rst_error", 32'(a_error), 32'd0);
      chk("rst_words", 32'(a_wl), 32'd0);
      idle(1);
      chk("post_rst_ready", 32'(a_ready), 32'd1);

`ifndef IMEM_LOADER_CHECKSUM_EN
      // two full words, in_last on lane 3
      send(8'h13, 0); send(8'h05, 0); send(8'h00, 0); send(8'h00, 0);
      send(8'h93, 0); send(8'h05, 0); send(8'h10, 0); send(8'h00, 1);
      chk("t1_we", 32'(a_we), 32'd1);
      chk("t1_done", 32'(a_done), 32'd1);
      chk("t1_core_reset", 32'(a_core_reset), 32'd0);
      chk("t1_words", 32'(a_wl), 32'd2);
      idle(1);
      chk("t1_nwrites", qa_addr.size(), 32'd2);
      chk("t1_addr0", qa_addr[0], 32'h0);
      chk("t1_data0", qa_data[0], 32'h0000_0513);
      chk("t1_addr1", qa_addr[1], 32'h4);
      chk("t1_data1", qa_data[1], 32'h0010_0593);
      // traffic while in DONE is ignored
      in_valid = 1'b1; in_byte = 8'hFF;
      idle(3);
      chk("t1_done_ready", 32'(a_ready), 32'd0);
      chk("t1_done_hold", 32'(a_done), 32'd1);
      chk("t1_done_words", 32'(a_wl), 32'd2);
      in_valid = 1'b0;
      idle(1);
      chk("t1_done_nwrites", qa_addr.size(), 32'd2);

      // partial flush on lane 0
      reset_a(); idle(1);
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0); send(8'hAA, 1);
      chk("t2_we", 32'(a_we), 32'd1);
      chk("t2_addr", a_addr, 32'h4);
      chk("t2_wdata", a_wdata, 32'h0000_00AA);
      chk("t2_done", 32'(a_done), 32'd1);
      chk("t2_error", 32'(a_error), 32'd0);
      idle(1);
      chk("t2_data0", qa_data[0], 32'h0403_0201);

      // reset mid-load discards progress
      reset_a(); idle(1);
      for (int i = 1; i <= 6; i++) send(8'(i), 0);
      reset_a();
      chk("t3_rst_words", 32'(a_wl), 32'd0);
      chk("t3_rst_core_reset", 32'(a_core_reset), 32'd1);
      idle(1);
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
      chk("t3_wdata", a_wdata, 32'h4433_2211);
      chk("t3_addr", a_addr, 32'h0);
      chk("t3_words", 32'(a_wl), 32'd1);
      idle(1);
      chk("t3_nwrites", qa_addr.size(), 32'd1);

      // instance b: gaps, base 0x100, fills all 3 words exactly
      ra = 1'b1; sel = 1'b1;
      reset_b(); idle(1);
      for (int i = 0; i < 12; i++) begin
         idle($urandom_range(0, 3));
         send(8'(8'h10 + i), i == 11);
      end
      chk("t4_done", 32'(b_done), 32'd1);
      chk("t4_error", 32'(b_error), 32'd0);
      chk("t4_words", 32'(b_wl), 32'd3);
      idle(1);
      chk("t4_nwrites", qb_addr.size(), 32'd3);
      chk("t4_addr0", qb_addr[0], 32'h100);
      chk("t4_addr1", qb_addr[1], 32'h104);
      chk("t4_addr2", qb_addr[2], 32'h108);
      chk("t4_data0", qb_data[0], 32'h1312_1110);
      chk("t4_data1", qb_data[1], 32'h1716_1514);
      chk("t4_data2", qb_data[2], 32'h1B1A_1918);

      // overflow: byte 13 would start word index 3
      reset_b(); idle(1);
      for (int i = 0; i < 12; i++) send(8'(i), 0);
      chk("t5_full_error", 32'(b_error), 32'd0);
      send(8'hEE, 0);
      chk("t5_error", 32'(b_error), 32'd1);
      chk("t5_core_reset", 32'(b_core_reset), 32'd1);
      chk("t5_done", 32'(b_done), 32'd0);
      chk("t5_we", 32'(b_we), 32'd0);
      chk("t5_words", 32'(b_wl), 32'd3);
      idle(2);
      chk("t5_ready", 32'(b_ready), 32'd0);
      chk("t5_nwrites", qb_addr.size(), 32'd3);
`else
      // checksum matches
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0); send(8'h04, 1);
      chk("c1_done", 32'(a_done), 32'd1);
      chk("c1_core_reset", 32'(a_core_reset), 32'd0);
      chk("c1_we", 32'(a_we), 32'd0);
      chk("c1_words", 32'(a_wl), 32'd1);
      idle(1);
      chk("c1_nwrites", qa_addr.size(), 32'd1);
      chk("c1_data", qa_data[0], 32'h0403_0201);

      // checksum mismatch
      reset_a(); idle(1);
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0); send(8'h05, 1);
      chk("c2_error", 32'(a_error), 32'd1);
      chk("c2_done", 32'(a_done), 32'd0);
      chk("c2_core_reset", 32'(a_core_reset), 32'd1);
      idle(1);
      chk("c2_data", qa_data[0], 32'h0403_0201);

      // partial word flushed by checksum byte
      reset_a(); idle(1);
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 1);
      chk("c3_we", 32'(a_we), 32'd1);
      chk("c3_wdata", a_wdata, 32'h0000_0201);
      chk("c3_done", 32'(a_done), 32'd1);

      // checksum as first byte
      reset_a(); idle(1);
      send(8'h00, 1);
      chk("c4_done", 32'(a_done), 32'd1);
      chk("c4_words", 32'(a_wl), 32'd0);
      idle(1);
      chk("c4_nwrites", qa_addr.size(), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader upstream of the single-cycle core's instruction memory. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and issues one write per word into instruction memory. Holds the core in reset until the image is complete, so the program counter starts fetching from a fully populated memory.

## Interface
Parameters:
- DEPTH_WORDS, 256: instruction memory capacity in 32-bit words.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_byte/in_last valid.
- in_ready  out  1  loader accepts a byte this cycle.
- in_byte  in  8  image byte.
- in_last  in  1  marks final byte of image.
- imem_we  out  1  one-cycle instruction memory write strobe.
- imem_addr  out  32  byte address of word written.
- imem_wdata  out  32  assembled word.
- core_reset  out  1  held high until load completes successfully.
- done  out  1  image loaded, core released.
- error  out  1  overflow or checksum failure.
- words_loaded  out  16  count of words written so far.

## Operation
- Handshake: byte accepted on a cycle with in_valid && in_ready. in_ready = 1 only in LOAD.
- Byte lane k (0..3) of the current word receives the k-th accepted byte of that word: lane 0 → wdata[7:0], lane 3 → wdata[31:24].
- Word write: on acceptance of lane-3 byte, next cycle imem_we=1, imem_wdata=assembled word, imem_addr=BASE_ADDR+4*words_loaded (pre-increment value); words_loaded increments the same cycle.
- Partial flush: in_last on lane 0..2 writes the word with unfilled upper lanes zero.
- States:
  - LOAD (after reset): accept bytes. in_last accepted → DONE (or ERROR per Configuration).
  - DONE: core_reset=0, done=1, in_ready=0. Exit only by reset.
  - ERROR: core_reset=1, error=1, in_ready=0. Exit only by reset.
- Overflow: a byte that would start word index DEPTH_WORDS is accepted but not stored; → ERROR, no write strobe. A full final word at index DEPTH_WORDS-1 is legal.
- in_valid while not in LOAD: ignored; no state change.
- Reset outputs: in_ready=0 during reset cycle, then 1; imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, done=0, error=0, words_loaded=0; lane pointer 0, partial bytes discarded.
- Reset mid-load: all progress discarded, no pending write issued; loading restarts at word 0.

## Timing
- All outputs registered.
- Word write latency: imem_we one cycle after accepting the completing byte (lane 3 or in_last).
- done/error and core_reset deassertion appear the cycle after accepting in_last, coincident with the final imem_we, if any.
- Overflow error asserts the cycle after the offending byte is accepted.
- Throughput: one byte per cycle; no back-pressure inside LOAD.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: the in_last byte is a checksum, not data. Loader keeps running XOR of all data bytes. On in_last: any pending partial word is flushed (zero-padded) as above; checksum == XOR → DONE, else → ERROR. in_last as the first byte: XOR=0, no words written.
- Undefined: in_last byte is ordinary data; in_last always → DONE unless overflow.

## Test plan
- Stream 8 bytes 13 05 00 00 93 05 10 00, in_last on byte 8 (macro off) → writes 0x00000513 @0x0, 0x00100593 @0x4; done=1, core_reset=0, words_loaded=2.
- Stream 5 bytes 01 02 03 04 AA, in_last on 5th → second write 0x000000AA @0x4; done on same cycle as that write.
- DEPTH_WORDS=2, stream 9 bytes → 2 writes, 9th byte triggers ERROR, no 3rd write, core_reset stays 1.
- Assert reset after 6 bytes, then stream 4 bytes 11 22 33 44 with in_last → single write 0x44332211 @BASE_ADDR, words_loaded=1.
- Macro on: bytes 01 02 03 04 then checksum 04 (in_last) → write 0x04030201, DONE; repeat with checksum 05 → same write, ERROR, core_reset=1.
- Random in_valid gaps, BASE_ADDR=0x100, 12 bytes → addresses 0x100, 0x104, 0x108, data unaffected by gaps.
